// File: rtl/cr_huf_comp_sc_long_pkg.sv
// Shared types and width constants for the long-alphabet symbol-count stage.
package cr_huf_compPKG;

   localparam int CREOLE_HC_LONG_DAT_WIDTH = 6;
   localparam int CREOLE_HC_LONG_CNT_WIDTH = 4;
   localparam int CREOLE_HC_SEQID_WIDTH    = 8;

   typedef enum logic [1:0] {
      SC_COUNT = 2'd0,
      SC_LOAD  = 2'd1,
      SC_DRAIN = 2'd2
   } e_sc_long_state;

   typedef struct packed {
      logic [CREOLE_HC_LONG_DAT_WIDTH-1:0] long;
      logic [CREOLE_HC_LONG_CNT_WIDTH-1:0] cnt;
      logic [CREOLE_HC_SEQID_WIDTH-1:0]    seq_id;
      logic                                eob;
   } s_sc_is_long_intf;

endpackage

// File: rtl/cr_huf_comp_sc_nz_find.sv
// Priority finder: first set mask bit at or above start, and whether any set bit lies beyond it.
module cr_huf_comp_sc_nz_find #(
   parameter int NUM_SYM   = 64,
   parameter int IDX_WIDTH = 6
) (
   input  logic [NUM_SYM-1:0]   mask,
   input  logic [IDX_WIDTH-1:0] start,
   output logic [IDX_WIDTH-1:0] idx,
   output logic                 found,
   output logic                 more_above
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      idx        = '0;
      found      = 1'b0;
      more_above = 1'b0;
      for (int i = 0; i < NUM_SYM; i++) begin
         if (mask[i] && (IDX_WIDTH'(i) >= start)) begin
            if (!found) begin
               idx   = IDX_WIDTH'(i);
               found = 1'b1;
            end else begin
               more_above = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cr_huf_comp_sc_long.sv
// Long-alphabet symbol counter: builds a per-block histogram, then drains
// non-zero (symbol, count) pairs in ascending order over a pull handshake.
module cr_huf_comp_sc_long
   import cr_huf_compPKG::*;
#(
   parameter int DAT_WIDTH = CREOLE_HC_LONG_DAT_WIDTH,
   parameter int CNT_WIDTH = CREOLE_HC_LONG_CNT_WIDTH,
   parameter int SEQ_WIDTH = CREOLE_HC_SEQID_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_vld,
   input  logic                 up_sym_vld,
   input  logic [DAT_WIDTH-1:0] up_sym,
   input  logic                 up_eob,
   input  logic [SEQ_WIDTH-1:0] up_seq_id,
   output logic                 up_rdy,
   output logic                 sc_is_long_vld,
   output s_sc_is_long_intf     sc_is_long_intf,
   input  logic                 is_sc_long_rd,
   output logic                 sc_long_sat
);

   localparam int NUM_SYM = 2 ** DAT_WIDTH;

   e_sc_long_state         state_q, state_d;
   logic [CNT_WIDTH-1:0]   hist_q [NUM_SYM];
   logic [CNT_WIDTH-1:0]   hist_d [NUM_SYM];
   s_sc_is_long_intf       out_q, out_d;
   logic                   vld_q, vld_d;
   logic                   rdy_q, rdy_d;
   logic                   sat_q, sat_d;
   logic [SEQ_WIDTH-1:0]   seq_q, seq_d;

   logic [NUM_SYM-1:0]     nz_mask;
   logic [DAT_WIDTH-1:0]   find_start;
   logic [DAT_WIDTH-1:0]   find_idx;
   logic                   find_found;
   logic                   find_more;
   logic [CNT_WIDTH-1:0]   cnt_inc;

   always_comb begin
      for (int i = 0; i < NUM_SYM; i++) nz_mask[i] = |hist_q[i];
   end

   // While draining, search strictly above the entry being presented.
   assign find_start = (state_q == SC_DRAIN) ? out_q.long + DAT_WIDTH'(1) : '0;

   cr_huf_comp_sc_nz_find #(
      .NUM_SYM   (NUM_SYM),
      .IDX_WIDTH (DAT_WIDTH)
   ) u_nz_find (
      .mask       (nz_mask),
      .start      (find_start),
      .idx        (find_idx),
      .found      (find_found),
      .more_above (find_more)
   );

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      out_d   = out_q;
      vld_d   = vld_q;
      seq_d   = seq_q;
      sat_d   = 1'b0;
      cnt_inc = hist_q[up_sym] + CNT_WIDTH'(1);
      unique case (state_q)
         SC_COUNT: begin
            if (up_vld && rdy_q) begin
               if (up_sym_vld && !(&hist_q[up_sym])) begin
                  hist_d[up_sym] = cnt_inc;
                  sat_d          = &cnt_inc;
               end
               if (up_eob) begin
                  seq_d   = up_seq_id;
                  state_d = SC_LOAD;
               end
            end
         end
         SC_LOAD: begin
            // An empty block still yields one marker entry {0, 0, seq, eob}.
            out_d.long   = find_found ? find_idx : '0;
            out_d.cnt    = find_found ? hist_q[find_idx] : '0;
            out_d.seq_id = seq_q;
            out_d.eob    = !find_more;
            vld_d        = 1'b1;
            state_d      = SC_DRAIN;
         end
         SC_DRAIN: begin
            if (is_sc_long_rd) begin
               hist_d[out_q.long] = '0;
               if (out_q.eob) begin
                  vld_d   = 1'b0;
                  state_d = SC_COUNT;
               end else begin
                  out_d.long = find_idx;
                  out_d.cnt  = hist_q[find_idx];
                  out_d.eob  = !find_more;
               end
            end
         end
         default: state_d = SC_COUNT;
      endcase
      rdy_d = (state_d == SC_COUNT);
   end

   // NOTE: the histogram is reset explicitly because a reset must discard any partially drained block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SC_COUNT;
         for (int i = 0; i < NUM_SYM; i++) hist_q[i] <= '0;
         out_q   <= '0;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b1;
         sat_q   <= 1'b0;
         seq_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state_q <= state_d;
         hist_q  <= hist_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
         sat_q   <= sat_d;
         seq_q   <= seq_d;
      end
   end

   assign up_rdy          = rdy_q;
   assign sc_is_long_vld  = vld_q;
   assign sc_is_long_intf = out_q;
   assign sc_long_sat     = sat_q;

endmodule

// File: tb/tb_cr_huf_comp_sc_long.sv
// Randomized scoreboard bench for cr_huf_comp_sc_long with directed timing and reset scenarios.
module tb_cr_huf_comp_sc_long;
   import cr_huf_compPKG::*;

   localparam int DW   = CREOLE_HC_LONG_DAT_WIDTH;
   localparam int CW   = CREOLE_HC_LONG_CNT_WIDTH;
   localparam int SW   = CREOLE_HC_SEQID_WIDTH;
   localparam int NS   = 1 << DW;
   localparam int CMAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             up_vld = 1'b0;
   logic             up_sym_vld = 1'b0;
   logic [DW-1:0]    up_sym = '0;
   logic             up_eob = 1'b0;
   logic [SW-1:0]    up_seq_id = '0;
   logic             up_rdy;
   logic             sc_is_long_vld;
   s_sc_is_long_intf sc_is_long_intf;
   logic             is_sc_long_rd;
   logic             sc_long_sat;

   always #5 clk = ~clk;

   cr_huf_comp_sc_long dut (
      .clk             (clk),
      .rst             (rst),
      .up_vld          (up_vld),
      .up_sym_vld      (up_sym_vld),
      .up_sym          (up_sym),
      .up_eob          (up_eob),
      .up_seq_id       (up_seq_id),
      .up_rdy          (up_rdy),
      .sc_is_long_vld  (sc_is_long_vld),
      .sc_is_long_intf (sc_is_long_intf),
      .is_sc_long_rd   (is_sc_long_rd),
      .sc_long_sat     (sc_long_sat)
   );

   int total = 0;
   int bad   = 0;
   s_sc_is_long_intf exp_q[$];
   int sat_seen = 0;
   int sat_exp  = 0;
   int model_hist [NS];
   int blk[$];
   int rd_mode = 0;
   logic manual_rd = 1'b0;
   int hold_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the block's histogram read out in ascending symbol order.
   task automatic push_expected(input logic [SW-1:0] seq);
      s_sc_is_long_intf e;
      int first = exp_q.size();
      int n = 0;
      for (int s = 0; s < NS; s++) begin
         if (model_hist[s] > 0) begin
            e.long   = DW'(s);
            e.cnt    = CW'((model_hist[s] > CMAX) ? CMAX : model_hist[s]);
            e.seq_id = seq;
            e.eob    = 1'b0;
            exp_q.push_back(e);
            n++;
            if (model_hist[s] >= CMAX) sat_exp++;
         end
         model_hist[s] = 0;
      end
      if (n == 0) begin
         e = '0;
         e.seq_id = seq;
         e.eob = 1'b1;
         exp_q.push_back(e);
      end else begin
         exp_q[first + n - 1].eob = 1'b1;
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rd_mode)
         0: is_sc_long_rd = 1'b1;
         1: is_sc_long_rd = 1'($urandom_range(0, 1));
         2: begin
            if (!sc_is_long_vld) hold_cnt = 0;
            else hold_cnt++;
            is_sc_long_rd = (hold_cnt > 10) && hold_cnt[0];
         end
         default: is_sc_long_rd = manual_rd;
      endcase
   end

   // Monitor: pops the scoreboard on every accepted entry.
   s_sc_is_long_intf held_v;
   logic held = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (sc_long_sat) sat_seen++;
         if (sc_is_long_vld) begin
            check("rdy_low_while_vld", 64'(up_rdy), 64'(0));
            if (held) check("entry_stable", 64'(sc_is_long_intf), 64'(held_v));
            if (is_sc_long_rd) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_entry: got %0h expected none", sc_is_long_intf);
               end else begin
                  check("entry", 64'(sc_is_long_intf), 64'(exp_q.pop_front()));
               end
            end
         end
         held   = sc_is_long_vld && !is_sc_long_rd;
         held_v = sc_is_long_intf;
      end
   end

   task automatic wait_rdy();
      int n = 0;
      while (!up_rdy) begin
         @(posedge clk); #1;
         n++;
         if (n > 3000) begin
            $display("FAIL up_rdy_timeout: got 0 expected 1");
            $fatal(1, "up_rdy never returned");
         end
      end
   endtask

   // Sends blk as one block; -1 marks a beat without a symbol, the last beat carries eob.
   task automatic send_block(input logic [SW-1:0] seq, input int gap_pct);
      if (blk.size() == 0) blk.push_back(-1);
      for (int i = 0; i < blk.size(); i++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(posedge clk); #1;
         end
         wait_rdy();
         up_vld     = 1'b1;
         up_sym_vld = (blk[i] >= 0);
         up_sym     = (blk[i] >= 0) ? DW'(blk[i]) : DW'($urandom);
         up_eob     = (i == blk.size() - 1);
         up_seq_id  = up_eob ? seq : SW'($urandom);
         if (blk[i] >= 0) model_hist[blk[i]]++;
         if (up_eob) push_expected(seq);
         @(posedge clk); #1;
         up_vld     = 1'b0;
         up_sym_vld = 1'b0;
         up_eob     = 1'b0;
      end
      blk.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (exp_q.size() != 0 || sc_is_long_vld) begin
         @(negedge clk);
         n++;
         if (n > 5000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            break;
         end
      end
      check("sat_pulses", 64'(sat_seen), 64'(sat_exp));
   endtask

   initial begin
      int hi;
      int sat0;
      for (int s = 0; s < NS; s++) model_hist[s] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_up_rdy", 64'(up_rdy), 64'(1));
      check("reset_vld", 64'(sc_is_long_vld), 64'(0));
      check("reset_intf", 64'(sc_is_long_intf), 64'(0));
      check("reset_sat", 64'(sc_long_sat), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic block with latency and drain-length checks.
      rd_mode = 0;
      blk = '{5, 5, 63, 0};
      send_block(8'h11, 0);
      @(negedge clk);
      check("load_vld_low", 64'(sc_is_long_vld), 64'(0));
      check("load_rdy_low", 64'(up_rdy), 64'(0));
      @(negedge clk);
      check("vld_at_t2", 64'(sc_is_long_vld), 64'(1));
      hi = 0;
      while (sc_is_long_vld && hi < 100) begin
         hi++;
         @(negedge clk);
      end
      check("vld_high_cycles", 64'(hi), 64'(3));
      check("rdy_after_eob_pop", 64'(up_rdy), 64'(1));
      wait_idle();

      // Empty block marker.
      send_block(8'h2A, 0);
      wait_idle();

      // Saturation: 17 beats of one symbol.
      sat0 = sat_seen;
      for (int i = 0; i < 17; i++) blk.push_back(9);
      send_block(8'h03, 0);
      wait_idle();
      check("sat_single_pulse", 64'(sat_seen - sat0), 64'(1));

      // Back-pressure: rd withheld, then every other cycle.
      rd_mode = 2;
      blk = '{1, 2, 3, 2, 40, -1, 7};
      send_block(8'h44, 10);
      wait_idle();

      // Back-to-back blocks.
      rd_mode = 0;
      blk = '{8, 8, 9};
      send_block(8'h50, 0);
      blk = '{8, 10};
      send_block(8'h51, 0);
      wait_idle();

      // Reset in the middle of a drain.
      rd_mode = 3;
      manual_rd = 1'b0;
      blk = '{1, 2, 2, 3, 3, 3};
      send_block(8'h60, 0);
      hi = 0;
      @(negedge clk);
      while (!sc_is_long_vld && hi < 50) begin
         hi++;
         @(negedge clk);
      end
      check("mid_drain_vld", 64'(sc_is_long_vld), 64'(1));
      manual_rd = 1'b1;
      @(posedge clk); #2;
      manual_rd = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_vld", 64'(sc_is_long_vld), 64'(0));
      check("rst_rdy", 64'(up_rdy), 64'(1));
      rd_mode = 0;
      blk = '{4, 4, 2};
      send_block(8'h61, 0);
      wait_idle();

      // Randomized blocks with mixed read patterns.
      for (int b = 0; b < 40; b++) begin
         int n;
         rd_mode = $urandom_range(0, 2);
         n = $urandom_range(0, 30);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) blk.push_back(-1);
            else if (b % 3 == 0) blk.push_back($urandom_range(0, 2));
            else blk.push_back($urandom_range(0, NS - 1));
         end
         send_block(SW'($urandom), $urandom_range(0, 30));
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
